// File: rtl/sch_pkt_desc_deq_pkg.sv
// Shared types and defaults for the scheduler
// packet-descriptor dequeue engine.
package sch_pkt_desc_deq_pkg;

  typedef struct packed {
    logic [3:0]  qid;
    logic [11:0] len;
    logic [15:0] addr;
  } sch_pkt_desc_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sch_deq_state_type;

  localparam int SCH_DEQ_INIT_CREDITS_DEF = 8;
  localparam int SCH_DEQ_CNT_NBITS_DEF    = 16;

endpackage

// File: rtl/sch_pkt_desc_skid.sv
// Two-entry valid/ready skid buffer; skid_full is
// registered so the upstream pop never sees out_ready.
module sch_pkt_desc_skid
  import sch_pkt_desc_deq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  sch_pkt_desc_type in_data_i,
  output logic             skid_full_o,
  output logic             out_valid_o,
  output sch_pkt_desc_type out_data_o,
  input  logic             out_ready_i
);

  logic             main_v_q;
  logic             skid_v_q;
  sch_pkt_desc_type main_q;
  sch_pkt_desc_type skid_q;
  logic             take;

  assign take        = ~main_v_q | out_ready_i;
  assign skid_full_o = skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;

  // Upstream only writes while the skid slot is free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (take) begin
      if (skid_v_q) begin
        main_q   <= skid_q;
        main_v_q <= 1'b1;
        skid_v_q <= in_valid_i;
        if (in_valid_i) skid_q <= in_data_i;
      end else begin
        main_v_q <= in_valid_i;
        if (in_valid_i) main_q <= in_data_i;
      end
    end else if (in_valid_i) begin
      skid_q   <= in_data_i;
      skid_v_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sch_pkt_desc_deq.sv
// Dequeue engine: pops the descriptor FIFO under a
// credit pool, supports flush-and-discard, keeps stats.
module sch_pkt_desc_deq
  import sch_pkt_desc_deq_pkg::*;
#(
  parameter int CREDIT_NBITS = 4,
  parameter int INIT_CREDITS = SCH_DEQ_INIT_CREDITS_DEF,
  parameter int CNT_NBITS    = SCH_DEQ_CNT_NBITS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  sch_pkt_desc_type      fifo_dout_i,
  output logic                  fifo_rd_o,
  output logic                  desc_valid_o,
  output sch_pkt_desc_type      desc_o,
  input  logic                  desc_ready_i,
  input  logic                  credit_ret_i,
  output logic [CREDIT_NBITS:0] credits_o,
  output logic                  busy_o,
  output logic                  flush_done_o,
  output logic [CNT_NBITS-1:0]  deq_cnt_o,
  output logic [CNT_NBITS-1:0]  drop_cnt_o
);

  localparam logic [CREDIT_NBITS:0] CRED_MAX =
    (CREDIT_NBITS+1)'(INIT_CREDITS);
  localparam logic [CREDIT_NBITS:0] CRED_ONE =
    (CREDIT_NBITS+1)'(1);
  localparam logic [CNT_NBITS-1:0] CNT_ONE =
    CNT_NBITS'(1);

  sch_deq_state_type     state_q;
  logic [CREDIT_NBITS:0] credits_q, credits_d;
  logic                  rd_prev_q;
  logic                  flush_done_q;
  logic [CNT_NBITS-1:0]  deq_cnt_q, drop_cnt_q;
  logic                  skid_full;
  logic                  run_pop, flush_pop;
  logic                  deliver, flush_exit;

  // Pops are held off during reset so the FIFO is untouched.
  always_comb begin
    fifo_rd_o = 1'b0;
    case (state_q)
      RUN:     fifo_rd_o = en_i & ~fifo_empty_i &
                           (credits_q != '0) & ~skid_full;
      FLUSH:   fifo_rd_o = ~fifo_empty_i;
      default: fifo_rd_o = 1'b0;
    endcase
    if (rst_i) fifo_rd_o = 1'b0;
  end

  assign run_pop    = fifo_rd_o & (state_q == RUN);
  assign flush_pop  = fifo_rd_o & (state_q == FLUSH);
  assign deliver    = desc_valid_o & desc_ready_i;
  // Empty flag lags a pop by one cycle.
  assign flush_exit = (state_q == FLUSH) & fifo_empty_i &
                      ~rd_prev_q;

  always_comb begin
    credits_d = credits_q;
    if (run_pop & ~credit_ret_i)
      credits_d = credits_q - CRED_ONE;
    else if (~run_pop & credit_ret_i &
             (credits_q != CRED_MAX))
      credits_d = credits_q + CRED_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      credits_q    <= CRED_MAX;
      rd_prev_q    <= 1'b0;
      flush_done_q <= 1'b0;
      deq_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      rd_prev_q    <= fifo_rd_o;
      flush_done_q <= flush_exit;
      credits_q    <= credits_d;
      if (deliver)   deq_cnt_q  <= deq_cnt_q + CNT_ONE;
      if (flush_pop) drop_cnt_q <= drop_cnt_q + CNT_ONE;
      if (flush_i && state_q != FLUSH) begin
        state_q <= FLUSH;
      end else begin
        case (state_q)
          IDLE:    if (en_i) state_q <= RUN;
          RUN:     if (!en_i) state_q <= IDLE;
          FLUSH:   if (flush_exit) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && credit_ret_i && !run_pop &&
        credits_q == CRED_MAX)
      $display("sch_pkt_desc_deq: error credit overflow %0t",
               $time);
  end
`endif

  sch_pkt_desc_skid u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (run_pop),
    .in_data_i   (fifo_dout_i),
    .skid_full_o (skid_full),
    .out_valid_o (desc_valid_o),
    .out_data_o  (desc_o),
    .out_ready_i (desc_ready_i)
  );

  assign credits_o    = credits_q;
  assign busy_o       = (state_q != IDLE) | desc_valid_o;
  assign flush_done_o = flush_done_q;
  assign deq_cnt_o    = deq_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_sch_pkt_desc_deq.sv
// Bench for sch_pkt_desc_deq: directed scenarios plus a
// randomized run against a queue/count reference model.
module tb_sch_pkt_desc_deq;
  import sch_pkt_desc_deq_pkg::*;

  logic clk = 1'b0;
  logic rst, en, flush, fifo_empty, fifo_rd;
  logic desc_valid, desc_ready, credit_ret;
  logic busy, flush_done;
  sch_pkt_desc_type fifo_dout, desc;
  logic [4:0]  credits;
  logic [15:0] deq_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int fd_cnt = 0;
  sch_pkt_desc_type fq[$];
  sch_pkt_desc_type obs[$];
  int pq[$];
  int dq[$];

  logic s_rd, s_v, s_fd, s_busy;
  sch_pkt_desc_type s_d;
  logic [4:0]  s_cred;
  logic [15:0] s_deq;

  always #5 clk = ~clk;

  sch_pkt_desc_deq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .flush_i      (flush),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_o    (fifo_rd),
    .desc_valid_o (desc_valid),
    .desc_o       (desc),
    .desc_ready_i (desc_ready),
    .credit_ret_i (credit_ret),
    .credits_o    (credits),
    .busy_o       (busy),
    .flush_done_o (flush_done),
    .deq_cnt_o    (deq_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  task automatic upd();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input sch_pkt_desc_type d);
    fq.push_back(d);
    upd();
  endtask

  function automatic sch_pkt_desc_type rnd();
    return sch_pkt_desc_type'($urandom);
  endfunction

  // Sample at negedge, then act as the FIFO after the edge.
  task automatic tick();
    @(negedge clk);
    s_rd = fifo_rd; s_v = desc_valid; s_d = desc;
    s_fd = flush_done; s_busy = busy;
    s_cred = credits; s_deq = deq_cnt;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rd && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
      pq.push_back(cyc);
    end
    if (s_v && desc_ready) begin
      obs.push_back(s_d);
      dq.push_back(cyc);
    end
    if (s_fd) fd_cnt++;
    upd();
  endtask

  task automatic clr_logs();
    pq.delete(); dq.delete(); obs.delete();
    pops = 0; fd_cnt = 0;
  endtask

  task automatic do_reset();
    fq.delete(); upd();
    rst = 1; en = 0; flush = 0;
    credit_ret = 0; desc_ready = 0;
    tick(); tick();
    rst = 0;
    clr_logs();
  endtask

  task automatic test_reset();
    upd();
    rst = 1; en = 0; flush = 0;
    credit_ret = 0; desc_ready = 0;
    tick(); tick();
    checks++; if (credits !== 5'd8) begin errors++;
      $display("FAIL rst_credits got %0d exp 8", credits); end
    checks++; if (desc_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b exp 0", desc_valid); end
    checks++; if (s_rd !== 1'b0) begin errors++;
      $display("FAIL rst_fifo_rd got %b exp 0", s_rd); end
    checks++; if (deq_cnt !== 16'd0) begin errors++;
      $display("FAIL rst_deq got %0d exp 0", deq_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++;
      $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (desc !== '0) begin errors++;
      $display("FAIL rst_desc got %h exp 0", desc); end
    rst = 0;
    clr_logs();
  endtask

  task automatic test_streaming();
    sch_pkt_desc_type d[3];
    do_reset();
    foreach (d[i]) begin d[i] = rnd(); push(d[i]); end
    en = 1; desc_ready = 1;
    repeat (8) tick();
    checks++; if (pops !== 3) begin errors++;
      $display("FAIL strm_pops got %0d exp 3", pops); end
    if (pq.size() == 3) begin
      checks++; if (pq[2] - pq[0] !== 2) begin errors++;
        $display("FAIL strm_burst got %0d exp 2", pq[2] - pq[0]); end
    end
    checks++; if (obs.size() !== 3) begin errors++;
      $display("FAIL strm_nout got %0d exp 3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size() &&
         i < pq.size(); i++) begin
      checks++; if (obs[i] !== d[i]) begin errors++;
        $display("FAIL strm_data%0d got %h exp %h", i, obs[i], d[i]); end
      checks++; if (dq[i] !== pq[i] + 1) begin errors++;
        $display("FAIL strm_lat%0d got %0d exp %0d", i, dq[i], pq[i] + 1); end
    end
    checks++; if (credits !== 5'd5) begin errors++;
      $display("FAIL strm_credits got %0d exp 5", credits); end
    checks++; if (deq_cnt !== 16'd3) begin errors++;
      $display("FAIL strm_deq got %0d exp 3", deq_cnt); end
    en = 0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL strm_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    sch_pkt_desc_type d[6];
    do_reset();
    foreach (d[i]) begin d[i] = rnd(); push(d[i]); end
    en = 1; desc_ready = 0;
    repeat (10) begin
      tick();
      if (s_v) begin
        checks++; if (s_d !== d[0]) begin errors++;
          $display("FAIL bp_stable got %h exp %h", s_d, d[0]); end
      end
    end
    checks++; if (pops !== 2) begin errors++;
      $display("FAIL bp_pops got %0d exp 2", pops); end
    checks++; if (desc_valid !== 1'b1) begin errors++;
      $display("FAIL bp_valid got %b exp 1", desc_valid); end
    desc_ready = 1;
    repeat (15) tick();
    checks++; if (obs.size() !== 6) begin errors++;
      $display("FAIL bp_nout got %0d exp 6", obs.size()); end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== d[i]) begin errors++;
        $display("FAIL bp_data%0d got %h exp %h", i, obs[i], d[i]); end
    end
    checks++; if (credits !== 5'd2) begin errors++;
      $display("FAIL bp_credits got %0d exp 2", credits); end
    checks++; if (deq_cnt !== 16'd6) begin errors++;
      $display("FAIL bp_deq got %0d exp 6", deq_cnt); end
  endtask

  task automatic test_credits();
    int rc;
    do_reset();
    repeat (10) push(rnd());
    en = 1; desc_ready = 1;
    repeat (20) tick();
    checks++; if (pops !== 8) begin errors++;
      $display("FAIL cr_pops got %0d exp 8", pops); end
    checks++; if (credits !== 5'd0) begin errors++;
      $display("FAIL cr_zero got %0d exp 0", credits); end
    credit_ret = 1; rc = cyc;
    tick();
    credit_ret = 0;
    tick(); tick();
    checks++; if (pops !== 9) begin errors++;
      $display("FAIL cr_ret_pops got %0d exp 9", pops); end
    if (pq.size() > 0) begin
      checks++; if (pq[pq.size()-1] !== rc + 2) begin errors++;
        $display("FAIL cr_ret_cyc got %0d exp %0d", pq[pq.size()-1], rc + 2); end
    end
    do_reset();
    repeat (5) push(rnd());
    en = 1; desc_ready = 1;
    repeat (12) tick();
    checks++; if (credits !== 5'd3) begin errors++;
      $display("FAIL cr_pre3 got %0d exp 3", credits); end
    push(rnd()); credit_ret = 1;
    tick();
    credit_ret = 0;
    checks++; if (s_rd !== 1'b1) begin errors++;
      $display("FAIL cr_coinc_rd got %b exp 1", s_rd); end
    checks++; if (credits !== 5'd3) begin errors++;
      $display("FAIL cr_coinc got %0d exp 3", credits); end
  endtask

  task automatic test_flush();
    sch_pkt_desc_type d0;
    do_reset();
    d0 = rnd();
    desc_ready = 0; en = 1;
    push(d0);
    for (int i = 0; i < 10 && pops == 0; i++) tick();
    en = 0;
    tick(); tick();
    repeat (4) push(rnd());
    flush = 1;
    tick();
    flush = 0;
    push(rnd());
    repeat (20) tick();
    checks++; if (pops !== 6) begin errors++;
      $display("FAIL fl_pops got %0d exp 6", pops); end
    checks++; if (drop_cnt !== 16'd5) begin errors++;
      $display("FAIL fl_drop got %0d exp 5", drop_cnt); end
    checks++; if (credits !== 5'd7) begin errors++;
      $display("FAIL fl_credits got %0d exp 7", credits); end
    checks++; if (fd_cnt !== 1) begin errors++;
      $display("FAIL fl_done got %0d exp 1", fd_cnt); end
    checks++; if (desc_valid !== 1'b1 || desc !== d0) begin errors++;
      $display("FAIL fl_staged got %b/%h exp 1/%h", desc_valid, desc, d0); end
    desc_ready = 1;
    repeat (3) tick();
    checks++; if (obs.size() !== 1) begin errors++;
      $display("FAIL fl_nout got %0d exp 1", obs.size()); end
    if (obs.size() > 0) begin
      checks++; if (obs[0] !== d0) begin errors++;
        $display("FAIL fl_data got %h exp %h", obs[0], d0); end
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL fl_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en = 1; desc_ready = 1;
    repeat (3) push(rnd());
    repeat (8) tick();
    desc_ready = 0;
    push(rnd());
    repeat (4) tick();
    checks++; if (credits !== 5'd4 || desc_valid !== 1'b1) begin errors++;
      $display("FAIL mr_pre got %0d/%b exp 4/1", credits, desc_valid); end
    push(rnd()); push(rnd());
    rst = 1;
    tick();
    rst = 0;
    checks++; if (s_rd !== 1'b0) begin errors++;
      $display("FAIL mr_rd_in_rst got %b exp 0", s_rd); end
    checks++; if (desc_valid !== 1'b0) begin errors++;
      $display("FAIL mr_valid got %b exp 0", desc_valid); end
    checks++; if (credits !== 5'd8) begin errors++;
      $display("FAIL mr_credits got %0d exp 8", credits); end
    checks++; if (fq.size() !== 2) begin errors++;
      $display("FAIL mr_fifo got %0d exp 2", fq.size()); end
    tick();
    checks++; if (s_rd !== 1'b0) begin errors++;
      $display("FAIL mr_rd_next got %b exp 0", s_rd); end
  endtask

  // Model: staged descriptors as a queue, credits as a count.
  task automatic test_random();
    sch_pkt_desc_type stg[$];
    sch_pkt_desc_type head, e_d;
    int m_cred, m_deq;
    bit m_run, e_rd, e_v, e_busy, rdy, ret;
    do_reset();
    m_cred = 8; m_deq = 0; m_run = 0;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      desc_ready = rdy;
      ret = (m_cred < 8) && ($urandom_range(0, 3) == 0);
      credit_ret = ret;
      if (fq.size() < 4 && $urandom_range(0, 2) == 0)
        push(rnd());
      e_rd = m_run && en && fq.size() > 0 &&
             m_cred > 0 && stg.size() < 2;
      e_v = (stg.size() > 0);
      e_d = e_v ? stg[0] : '0;
      e_busy = m_run || e_v;
      head = (fq.size() > 0) ? fq[0] : '0;
      tick();
      checks++; if (s_rd !== e_rd) begin errors++;
        $display("FAIL rnd_rd@%0d got %b exp %b", i, s_rd, e_rd); end
      checks++; if (s_v !== e_v) begin errors++;
        $display("FAIL rnd_valid@%0d got %b exp %b", i, s_v, e_v); end
      if (e_v) begin
        checks++; if (s_d !== e_d) begin errors++;
          $display("FAIL rnd_desc@%0d got %h exp %h", i, s_d, e_d); end
      end
      checks++; if (s_cred !== 5'(m_cred)) begin errors++;
        $display("FAIL rnd_cred@%0d got %0d exp %0d", i, s_cred, m_cred); end
      checks++; if (s_deq !== 16'(m_deq)) begin errors++;
        $display("FAIL rnd_deq@%0d got %0d exp %0d", i, s_deq, m_deq); end
      checks++; if (s_busy !== e_busy) begin errors++;
        $display("FAIL rnd_busy@%0d got %b exp %b", i, s_busy, e_busy); end
      if (e_v && rdy) begin
        void'(stg.pop_front());
        m_deq++;
      end
      if (e_rd) stg.push_back(head);
      m_cred = m_cred + (ret ? 1 : 0) - (e_rd ? 1 : 0);
      m_run = en;
    end
    en = 0; credit_ret = 0; desc_ready = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_credits();
    test_flush();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sch_pkt_desc_deq.md
Name: sch_pkt_desc_deq

Overview:
- Read-side dequeue engine for the scheduler packet-descriptor FIFO (sfifo_sch_pkt_desc).
- Pops descriptors from the FIFO head and presents them to the downstream scheduler stage on a valid/ready interface.
- Gates pops on a downstream credit pool, supports a flush that drains and discards FIFO contents, and keeps dequeue/drop statistics.

Parameters:
- CREDIT_NBITS, 4, width of credit counter minus one. The credits port is CREDIT_NBITS+1 bits.
- INIT_CREDITS, 8, credits loaded at reset; the maximum the pool may hold.
- CNT_NBITS, 16, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  dequeue enable (level).
- flush  in  1  single-cycle request to drain and discard FIFO contents.
- fifo_empty  in  1  FIFO empty flag; fifo_dout is valid whenever this is 0.
- fifo_dout  in  sch_pkt_desc_type  FIFO head descriptor.
- fifo_rd  out  1  FIFO pop, combinational.
- desc_valid  out  1  downstream descriptor valid.
- desc  out  sch_pkt_desc_type  downstream descriptor.
- desc_ready  in  1  downstream accept.
- credit_ret  in  1  one credit returned by downstream.
- credits  out  CREDIT_NBITS+1  current credit count.
- busy  out  1  state!=IDLE or desc_valid.
- flush_done  out  1  single-cycle pulse at flush completion.
- deq_cnt  out  CNT_NBITS  descriptors delivered downstream.
- drop_cnt  out  CNT_NBITS  descriptors discarded by flush.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - credits=INIT_CREDITS.
  - desc_valid=0, flush_done=0, deq_cnt=0, drop_cnt=0, desc=0.
  - State = IDLE. Skid stage emptied.
  - Reset mid-operation discards staged descriptors; FIFO contents are untouched.
- FSM:
  - IDLE: go to RUN when en=1.
  - RUN: go to IDLE when en=0.
  - FLUSH: entered from any state when flush=1 (flush has priority over en). Exits to IDLE when fifo_empty=1 and fifo_rd was 0 in the previous cycle, because the FIFO flag updates one cycle after a pop. flush_done pulses on that exit cycle.
- fifo_rd:
  - RUN: en & ~fifo_empty & (credits!=0) & ~skid_full.
  - FLUSH: ~fifo_empty.
  - Otherwise 0.
  - fifo_rd never asserts while fifo_empty=1.
- Output stage:
  - Two-entry skid (main + skid register), so fifo_rd has no combinational path from desc_ready.
  - A pop in cycle N gives desc_valid=1 in cycle N+1 when the stage was empty (1-cycle latency).
  - Once desc_valid=1, desc stays stable until desc_valid & desc_ready.
  - Order is preserved.
  - Full-rate streaming is sustained when desc_ready=1 every cycle.
- Flush:
  - Descriptors already in the output stage are retained and delivered normally.
  - Only FIFO contents are discarded, including descriptors written during FLUSH.
  - drop_cnt increments per FLUSH pop.
  - flush=1 while already in FLUSH is ignored.
- Credits:
  - RUN pop decrements credits; credit_ret increments.
  - Simultaneous pop and credit_ret leave credits unchanged.
  - FLUSH pops consume no credits.
  - credit_ret with credits==INIT_CREDITS and no pop: credits held, diagnostic $display error (sim only).
- Counters:
  - deq_cnt increments on desc_valid & desc_ready.
  - Both deq_cnt and drop_cnt wrap modulo 2^CNT_NBITS.
- en deasserted mid-stream: fifo_rd drops the same cycle; staged descriptors are still delivered; busy stays 1 until the stage is empty.

Decomposition:
- meta_package:
  - sch_pkt_desc_type (existing).
  - New enum sch_deq_state_type {IDLE, RUN, FLUSH}.
  - Constants SCH_DEQ_INIT_CREDITS_DEF=8 and SCH_DEQ_CNT_NBITS_DEF=16.
- One sub-module: sch_pkt_desc_skid.
  - Two-entry valid/ready skid buffer for sch_pkt_desc_type.
  - Ports in_valid/in_data/skid_full/out_valid/out_data/out_ready.
- FSM, credit logic and counters live in the top.

Test Plan:
- Reset: hold rst 2 cycles -> credits=8, desc_valid=0, fifo_rd=0, deq_cnt=drop_cnt=0, busy=0.
- Streaming: FIFO holds D0..D2, en=1, desc_ready=1 -> fifo_rd in cycles N..N+2; desc=D0,D1,D2 valid in N+1..N+3; credits 8->5; deq_cnt=3.
- Backpressure: 6 descriptors, desc_ready=0 -> exactly 2 pops, desc=D0 stable. Raise desc_ready -> D0..D5 delivered in order, no loss or duplication.
- Credit exhaustion: INIT_CREDITS=8, 10 descriptors, no credit_ret -> exactly 8 pops, credits=0. One credit_ret -> 9th pop next cycle. credit_ret coincident with a pop at credits=3 -> credits stays 3.
- Flush: 1 descriptor staged with desc_ready=0, 5 in FIFO, pulse flush -> 5 pops, drop_cnt=5, credits unchanged, single flush_done pulse, state IDLE. Staged descriptor delivered once desc_ready=1.
- Reset mid-run: rst asserted while desc_valid=1 and credits=4 -> next cycle desc_valid=0, credits=8, fifo_rd=0.
